bcd_counter_9999: RTL and testbench



---
 rtl/bcd_pkg.sv | 50 +++++
 rtl/bcd_counter_9999_if.sv | 28 ++
 rtl/bin2bcd_seq.sv | 94 +++++++++
 rtl/bcd_counter_9999.sv | 76 +++++++
 tb/tb_bcd_counter_9999.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and BCD helpers for the four-digit up/down counter.
package bcd_pkg;

    localparam int BCD_MAX = 9999;
    localparam int DIGITS  = 4;
    localparam int BCD_W   = 4 * DIGITS;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Ripple increment/decrement across digits; each digit wraps 9<->0 and passes a carry/borrow on.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] v, input logic up);
        logic [BCD_W-1:0] r;
        logic             c;
        nibble_t          d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c           = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_at_limit(input logic [BCD_W-1:0] v, input logic up);
        return up ? (v == 16'h9999) : (v == 16'h0000);
    endfunction

endpackage

// File: rtl/bcd_counter_9999_if.sv
// Control and digit bus between the counter and its driver / display stage.
interface bcd_counter_9999_if #(
    parameter int LOAD_W = 14
);
    import bcd_pkg::*;

    logic              en;
    logic              up_dn;
    logic              load;
    logic [LOAD_W-1:0] load_val;
    nibble_t           bcd0;
    nibble_t           bcd1;
    nibble_t           bcd2;
    nibble_t           bcd3;
    logic              busy;
    logic              wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  bcd0, bcd1, bcd2, bcd3, busy, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bcd0, bcd1, bcd2, bcd3, busy, wrap
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle.
// IDLE: wait for start | SHIFT: add-3 then shift, BIN_W cycles | DONE: bcd_out valid, one cycle
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] scr_q, scr_d, scr_adj;
    logic             cnt_tc;

    assign cnt_tc = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = SHIFT;
            SHIFT:   if (cnt_tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        bin_d = bin_q;
        scr_d = scr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = bin_in;
                    scr_d = '0;
                    cnt_d = CNT_W'(BIN_W - 1);
                end
            end
            SHIFT: begin
                scr_d = {scr_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                if (!cnt_tc) cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            bin_q <= '0;
            scr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            bin_q <= bin_d;
            scr_q <= scr_d;
        end
    end

    assign bcd_out = scr_q;

endmodule

// File: rtl/bcd_counter_9999.sv
// Four-digit BCD up/down counter with prescaled stepping and a binary load
// path through the sequential converter.
module bcd_counter_9999
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int LOAD_W   = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_counter_9999_if.slave  bus
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic              step;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic              wrap_q, wrap_d;
    logic [LOAD_W-1:0] load_sat;
    logic              conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    assign load_sat   = (32'(bus.load_val) > 32'(BCD_MAX)) ? LOAD_W'(BCD_MAX) : bus.load_val;
    assign conv_start = bus.load & ~conv_busy;

    // A load in the tick cycle takes priority, so that tick is lost rather than deferred.
    assign step = tick & bus.en & ~conv_busy & ~bus.load;

    bin2bcd_seq #(
        .BIN_W (LOAD_W)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin_in  (load_sat),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (conv_done) begin
            digits_d = conv_bcd;
        end else if (step) begin
            digits_d = bcd_step(digits_q, bus.up_dn);
            wrap_d   = bcd_at_limit(digits_q, bus.up_dn);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            digits_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.bcd0 = digits_q[3:0];
    assign bus.bcd1 = digits_q[7:4];
    assign bus.bcd2 = digits_q[11:8];
    assign bus.bcd3 = digits_q[15:12];
    assign bus.busy = conv_busy;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_9999.sv
// Scoreboard bench: stimulus queues expected digit changes and busy lengths, a monitor checks them.
module tb_bcd_counter_9999;
    import bcd_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int LOAD_W   = 14;

    typedef struct packed {
        logic [15:0] digits;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    exp_t dig_q[$];
    int   busy_q[$];

    always #5 clk = ~clk;

    bcd_counter_9999_if #(.LOAD_W(LOAD_W)) bus ();

    bcd_counter_9999 #(
        .TICK_DIV (TICK_DIV),
        .LOAD_W   (LOAD_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Edges since reset release; prescaler == edge_cnt % TICK_DIV, so steps land on multiples of TICK_DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [15:0] shown();
        return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_d(input logic [15:0] d, input logic w);
        exp_t e;
        e.digits = d;
        e.wrap   = w;
        dig_q.push_back(e);
    endtask

    task automatic tick_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic align();
        while (edge_cnt % TICK_DIV != 0) tick_edges(1);
    endtask

    task automatic do_load(input logic [LOAD_W-1:0] v, input logic [15:0] exp);
        logic [15:0] old;
        old          = shown();
        bus.load     = 1'b1;
        bus.load_val = v;
        expect_d(exp, 1'b0);
        busy_q.push_back(LOAD_W + 1);
        tick_edges(1);
        bus.load = 1'b0;
        chk("busy_after_load", {31'd0, bus.busy}, 32'd1);
        tick_edges(LOAD_W);
        chk("hold_during_conv", {15'd0, bus.busy, shown()}, {15'd0, 1'b1, old});
        tick_edges(1);
        chk("load_result", {15'd0, bus.busy, shown()}, {15'd0, 1'b0, exp});
    endtask

    initial begin : monitor
        logic [15:0] prev;
        int          blen;
        exp_t        e;
        prev = '0;
        blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = shown();
                blen = 0;
            end else begin
                if (shown() !== prev || bus.wrap === 1'b1) begin
                    if (dig_q.size() == 0) begin
                        chk("unexpected_output", {15'd0, bus.wrap, shown()}, {15'd0, 1'b0, prev});
                    end else begin
                        e = dig_q.pop_front();
                        chk("digits", {16'd0, shown()}, {16'd0, e.digits});
                        chk("wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
                    end
                end
                prev = shown();
                if (bus.busy === 1'b1) begin
                    blen++;
                end else if (blen > 0) begin
                    if (busy_q.size() == 0) chk("unexpected_busy", blen, 0);
                    else                    chk("busy_len", blen, busy_q.pop_front());
                    blen = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #12;
        chk("reset_digits", {16'd0, shown()}, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_wrap", {31'd0, bus.wrap}, 32'd0);
        #10 rst_n = 1'b1;
        tick_edges(1);

        do_load(14'd1234,  16'h1234);
        do_load(14'd12000, 16'h9999);

        // Up across the top: 9998 -> 9999 -> 0000 with a single wrap pulse.
        do_load(14'd9998,  16'h9998);
        align();
        bus.up_dn = 1'b1;
        bus.en    = 1'b1;
        expect_d(16'h9999, 1'b0);
        expect_d(16'h0000, 1'b1);
        tick_edges(2 * TICK_DIV);
        bus.en = 1'b0;

        do_load(14'd1, 16'h0001);
        align();
        bus.up_dn = 1'b0;
        bus.en    = 1'b1;
        expect_d(16'h0000, 1'b0);
        expect_d(16'h9999, 1'b1);
        tick_edges(2 * TICK_DIV);
        bus.en = 1'b0;

        do_load(14'd1000, 16'h1000);
        align();
        bus.en = 1'b1;
        expect_d(16'h0999, 1'b0);
        tick_edges(TICK_DIV);
        bus.en = 1'b0;

        // Load in the tick cycle, then a second load while busy; ticks during busy are lost.
        align();
        bus.up_dn = 1'b1;
        bus.en    = 1'b1;
        tick_edges(TICK_DIV - 1);
        bus.load     = 1'b1;
        bus.load_val = 14'd4321;
        expect_d(16'h4321, 1'b0);
        busy_q.push_back(LOAD_W + 1);
        tick_edges(1);
        bus.load = 1'b0;
        chk("coincident_busy", {31'd0, bus.busy}, 32'd1);
        tick_edges(4);
        bus.load     = 1'b1;
        bus.load_val = 14'd5555;
        tick_edges(1);
        bus.load = 1'b0;
        tick_edges(LOAD_W - 4);
        chk("coincident_result", {15'd0, bus.busy, shown()}, {15'd0, 1'b0, 16'h4321});
        expect_d(16'h4322, 1'b0);
        tick_edges(1);
        bus.en = 1'b0;

        // Disabled for three tick periods, then exactly one step per tick; direction flips mid-period.
        tick_edges(3 * TICK_DIV);
        chk("hold_while_disabled", {16'd0, shown()}, 32'h4322);
        align();
        bus.en = 1'b1;
        expect_d(16'h4323, 1'b0);
        tick_edges(TICK_DIV + 1);
        bus.up_dn = 1'b0;
        expect_d(16'h4322, 1'b0);
        tick_edges(TICK_DIV - 1);
        bus.en = 1'b0;

        // Asynchronous reset during a conversion.
        do_load(14'd457, 16'h0457);
        bus.load     = 1'b1;
        bus.load_val = 14'd1111;
        tick_edges(1);
        bus.load = 1'b0;
        tick_edges(4);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_digits", {16'd0, shown()}, 32'h0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_wrap", {31'd0, bus.wrap}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick_edges(LOAD_W + 6);
        chk("aborted_conv_digits", {15'd0, bus.busy, shown()}, 32'h0);

        tick_edges(3);
        chk("digit_queue_drained", dig_q.size(), 0);
        chk("busy_queue_drained", busy_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
